// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: 4-stage signed pre-add / multiply / post-add MAC slice.
// Valid and OPMODE travel with each sample; optional saturation, overflow
// flag and masked pattern detect are registered alongside P.
//
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   CE              global enable, 0 freezes every pipeline register
//   RSTP            sync clear of P / OVERFLOW / PATTERNDETECT
//   IN_VALID        sample valid at stage 0
//   OPMODE[7:0]     per-sample mode (X, Z, mult B source, CIN, pre-sub, post-sub)
//   A, B, D, C      signed operands
//   PCIN            cascade input
//   M               stage-3 product register
//   P, PCOUT        accumulator / result (PCOUT == P)
//   OUT_VALID       P holds a newly produced sample
//   OVERFLOW        sample in P overflowed the signed P range
//   PATTERNDETECT   ((P ^ PATTERN) & ~MASK) == 0
module dsp_mac_pipe #(
    parameter int A_WIDTH = 18,
    parameter int B_WIDTH = 18,
    parameter int D_WIDTH = 18,
    parameter int C_WIDTH = 48,
    parameter int P_WIDTH = 48,
    parameter bit SAT_EN  = 1'b0,
    parameter logic [P_WIDTH-1:0] PATTERN = '0,
    parameter logic [P_WIDTH-1:0] MASK = {{(P_WIDTH-8){1'b1}}, 8'h00},
    localparam int PRE_W = ((B_WIDTH > D_WIDTH) ? B_WIDTH : D_WIDTH) + 1,
    localparam int M_W   = A_WIDTH + PRE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      CE,
    input  logic                      RSTP,
    input  logic                      IN_VALID,
    input  logic [7:0]                OPMODE,
    input  logic signed [A_WIDTH-1:0] A,
    input  logic signed [B_WIDTH-1:0] B,
    input  logic signed [D_WIDTH-1:0] D,
    input  logic signed [C_WIDTH-1:0] C,
    input  logic signed [P_WIDTH-1:0] PCIN,
    output logic signed [M_W-1:0]     M,
    output logic signed [P_WIDTH-1:0] P,
    output logic signed [P_WIDTH-1:0] PCOUT,
    output logic                      OUT_VALID,
    output logic                      OVERFLOW,
    output logic                      PATTERNDETECT
);

    localparam int SUM_W = P_WIDTH + 2;

    // Stage 1
    logic                      s1_v;
    logic [7:0]                s1_op;
    logic signed [A_WIDTH-1:0] s1_a;
    logic signed [B_WIDTH-1:0] s1_b;
    logic signed [D_WIDTH-1:0] s1_d;
    logic signed [C_WIDTH-1:0] s1_c;
    logic signed [P_WIDTH-1:0] s1_pcin;

    // Stage 2 (op keeps only fields still needed: {post_sub, cin, z, x})
    logic                      s2_v;
    logic [5:0]                s2_op;
    logic signed [A_WIDTH-1:0] s2_a;
    logic signed [PRE_W-1:0]   s2_bm;
    logic [P_WIDTH-1:0]        s2_dab;
    logic signed [C_WIDTH-1:0] s2_c;
    logic signed [P_WIDTH-1:0] s2_pcin;

    // Stage 3
    logic                      s3_v;
    logic [5:0]                s3_op;
    logic [P_WIDTH-1:0]        s3_dab;
    logic signed [C_WIDTH-1:0] s3_c;
    logic signed [P_WIDTH-1:0] s3_pcin;

    // Pre-adder, sized one bit wider than the widest input so it never wraps
    logic signed [PRE_W-1:0] b_ext;
    logic signed [PRE_W-1:0] d_ext;
    logic signed [PRE_W-1:0] pre_sum;
    logic signed [PRE_W-1:0] mul_b;
    logic [P_WIDTH-1:0]      dab;
    logic [5:0]              op_fwd;

    assign b_ext   = {{(PRE_W-B_WIDTH){s1_b[B_WIDTH-1]}}, s1_b};
    assign d_ext   = {{(PRE_W-D_WIDTH){s1_d[D_WIDTH-1]}}, s1_d};
    assign pre_sum = s1_op[6] ? (d_ext - b_ext) : (d_ext + b_ext);
    assign mul_b   = s1_op[4] ? pre_sum : b_ext;
    assign dab     = P_WIDTH'({s1_d, s1_a, s1_b});
    assign op_fwd  = {s1_op[7], s1_op[5], s1_op[3:0]};

    // Multiplier operands widened to the full product width
    logic signed [M_W-1:0] a_m;
    logic signed [M_W-1:0] b_m;
    logic signed [M_W-1:0] product;

    assign a_m     = {{PRE_W{s2_a[A_WIDTH-1]}}, s2_a};
    assign b_m     = {{A_WIDTH{s2_bm[PRE_W-1]}}, s2_bm};
    assign product = a_m * b_m;

    // Post-adder, two guard bits so overflow is visible before wrap/clamp
    logic signed [SUM_W-1:0] m_ext;
    logic signed [SUM_W-1:0] p_ext;
    logic signed [SUM_W-1:0] dab_ext;
    logic signed [SUM_W-1:0] c_ext;
    logic signed [SUM_W-1:0] pcin_ext;
    logic signed [SUM_W-1:0] cin_ext;
    logic signed [SUM_W-1:0] x_val;
    logic signed [SUM_W-1:0] z_val;
    logic signed [SUM_W-1:0] sum;
    logic [2:0]              sum_top;
    logic                    ovf;
    logic [P_WIDTH-1:0]      p_next;
    logic                    pd_next;

    assign m_ext    = {{(SUM_W-M_W){M[M_W-1]}}, M};
    assign p_ext    = {{2{P[P_WIDTH-1]}}, P};
    assign dab_ext  = {{2{s3_dab[P_WIDTH-1]}}, s3_dab};
    assign c_ext    = {{(SUM_W-C_WIDTH){s3_c[C_WIDTH-1]}}, s3_c};
    assign pcin_ext = {{2{s3_pcin[P_WIDTH-1]}}, s3_pcin};
    assign cin_ext  = SUM_W'(s3_op[4]);

    always_comb begin
        x_val = '0;
        z_val = '0;
        unique case (s3_op[1:0])
            2'd0:    x_val = '0;
            2'd1:    x_val = m_ext;
            2'd2:    x_val = p_ext;
            default: x_val = dab_ext;
        endcase
        unique case (s3_op[3:2])
            2'd0:    z_val = '0;
            2'd1:    z_val = pcin_ext;
            2'd2:    z_val = p_ext;
            default: z_val = c_ext;
        endcase
    end

    assign sum = s3_op[5] ? (z_val - (x_val + cin_ext))
                          : (z_val + x_val + cin_ext);

    // In range only when the guard bits match the P sign bit
    assign sum_top = sum[SUM_W-1:P_WIDTH-1];
    assign ovf     = !((&sum_top) || !(|sum_top));

    always_comb begin
        p_next = sum[P_WIDTH-1:0];
        if (SAT_EN && ovf) begin
            p_next = sum[SUM_W-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                  : {1'b0, {(P_WIDTH-1){1'b1}}};
        end
    end

    assign pd_next = (((p_next ^ PATTERN) & ~MASK) == '0);

    // Pipeline stages 1-3, product register and output valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_op     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_d      <= '0;
            s1_c      <= '0;
            s1_pcin   <= '0;
            s2_v      <= 1'b0;
            s2_op     <= '0;
            s2_a      <= '0;
            s2_bm     <= '0;
            s2_dab    <= '0;
            s2_c      <= '0;
            s2_pcin   <= '0;
            s3_v      <= 1'b0;
            s3_op     <= '0;
            s3_dab    <= '0;
            s3_c      <= '0;
            s3_pcin   <= '0;
            M         <= '0;
            OUT_VALID <= 1'b0;
        end else if (CE) begin
            s1_v      <= IN_VALID;
            s1_op     <= OPMODE;
            s1_a      <= A;
            s1_b      <= B;
            s1_d      <= D;
            s1_c      <= C;
            s1_pcin   <= PCIN;
            s2_v      <= s1_v;
            s2_op     <= op_fwd;
            s2_a      <= s1_a;
            s2_bm     <= mul_b;
            s2_dab    <= dab;
            s2_c      <= s1_c;
            s2_pcin   <= s1_pcin;
            s3_v      <= s2_v;
            s3_op     <= s2_op;
            s3_dab    <= s2_dab;
            s3_c      <= s2_c;
            s3_pcin   <= s2_pcin;
            M         <= product;
            OUT_VALID <= s3_v;
        end
    end

    // Stage 4: bubbles hold P so accumulation only counts valid samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            P             <= '0;
            OVERFLOW      <= 1'b0;
            PATTERNDETECT <= 1'b0;
        end else if (RSTP) begin
            P             <= '0;
            OVERFLOW      <= 1'b0;
            PATTERNDETECT <= 1'b0;
        end else if (CE && s3_v) begin
            P             <= p_next;
            OVERFLOW      <= ovf;
            PATTERNDETECT <= pd_next;
        end
    end

    assign PCOUT = P;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb_dsp_mac_pipe: directed + randomized checks of dsp_mac_pipe against
// a sample-level arithmetic reference model (wrap and saturating instances).
module tb_dsp_mac_pipe;

    localparam longint TWO47 = 64'sh0000_8000_0000_0000;
    localparam longint TWO48 = 64'sh0001_0000_0000_0000;
    localparam longint MAXP  = TWO47 - 1;
    localparam longint MINP  = -TWO47;

    logic clk = 1'b0;
    logic rst_n;
    logic ce;
    logic rstp;
    logic in_valid;
    logic [7:0] opmode;
    logic signed [17:0] a;
    logic signed [17:0] b;
    logic signed [17:0] d;
    logic signed [47:0] c;
    logic signed [47:0] pcin;

    logic [36:0] m0, m1;
    logic [47:0] p0, p1, pc0, pc1;
    logic vo0, vo1, ov0, ov1, pd0, pd1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dsp_mac_pipe #(.SAT_EN(1'b0), .PATTERN(48'h40)) dut0 (
        .clk(clk), .rst_n(rst_n), .CE(ce), .RSTP(rstp),
        .IN_VALID(in_valid), .OPMODE(opmode),
        .A(a), .B(b), .D(d), .C(c), .PCIN(pcin),
        .M(m0), .P(p0), .PCOUT(pc0), .OUT_VALID(vo0),
        .OVERFLOW(ov0), .PATTERNDETECT(pd0)
    );

    dsp_mac_pipe #(.SAT_EN(1'b1), .PATTERN(48'h40)) dut1 (
        .clk(clk), .rst_n(rst_n), .CE(ce), .RSTP(rstp),
        .IN_VALID(in_valid), .OPMODE(opmode),
        .A(a), .B(b), .D(d), .C(c), .PCIN(pcin),
        .M(m1), .P(p1), .PCOUT(pc1), .OUT_VALID(vo1),
        .OVERFLOW(ov1), .PATTERNDETECT(pd1)
    );

    typedef struct {
        bit         v;
        logic [7:0] op;
        longint     a, b, d, c, pcin;
    } samp_t;

    // Samples accepted but not yet retired into P, oldest first
    samp_t  pend[$];
    longint pexp[2];
    bit     ovexp[2];
    bit     pdexp[2];
    longint mexp;
    bit     voexp;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint wrap48(longint v);
        longint w;
        w = v & (TWO48 - 1);
        if (w >= TWO47) w = w - TWO48;
        return w;
    endfunction

    function automatic longint prod(samp_t s);
        longint pre;
        pre = s.op[6] ? (s.d - s.b) : (s.d + s.b);
        return s.a * (s.op[4] ? pre : s.b);
    endfunction

    function automatic longint calc(samp_t s, longint pc);
        longint x, z, cin, dab;
        dab = wrap48(((s.d & 64'h3FFFF) << 36) | ((s.a & 64'h3FFFF) << 18)
                     | (s.b & 64'h3FFFF));
        case (s.op[1:0])
            2'd0: x = 0;
            2'd1: x = prod(s);
            2'd2: x = pc;
            default: x = dab;
        endcase
        case (s.op[3:2])
            2'd0: z = 0;
            2'd1: z = s.pcin;
            2'd2: z = pc;
            default: z = s.c;
        endcase
        cin = s.op[5] ? 1 : 0;
        if (s.op[7]) return z - (x + cin);
        return z + x + cin;
    endfunction

    function automatic void reset_model();
        samp_t z;
        z = '{default: 0};
        pend.delete();
        repeat (3) pend.push_back(z);
        for (int i = 0; i < 2; i++) begin
            pexp[i] = 0; ovexp[i] = 0; pdexp[i] = 0;
        end
        mexp = 0;
        voexp = 0;
    endfunction

    function automatic void model_edge();
        samp_t cur, out;
        bit load;
        longint r;
        out = '{default: 0};
        cur.v = in_valid; cur.op = opmode;
        cur.a = a; cur.b = b; cur.d = d; cur.c = c; cur.pcin = pcin;
        load = 0;
        if (ce) begin
            out = pend.pop_front();
            pend.push_back(cur);
            mexp = prod(pend[0]);
            voexp = out.v;
            load = out.v;
        end
        for (int i = 0; i < 2; i++) begin
            if (rstp) begin
                pexp[i] = 0; ovexp[i] = 0; pdexp[i] = 0;
            end else if (load) begin
                r = calc(out, pexp[i]);
                ovexp[i] = (r > MAXP) || (r < MINP);
                if (i == 1) pexp[i] = (r > MAXP) ? MAXP : (r < MINP) ? MINP : r;
                else pexp[i] = wrap48(r);
                pdexp[i] = ((pexp[i] & 255) == 64'h40);
            end
        end
    endfunction

    task automatic check_all();
        chk("out_valid0", vo0, voexp);
        chk("out_valid1", vo1, voexp);
        chk("m0", m0, mexp[36:0]);
        chk("m1", m1, mexp[36:0]);
        chk("p_wrap", p0, pexp[0][47:0]);
        chk("p_sat", p1, pexp[1][47:0]);
        chk("pcout", pc0, pexp[0][47:0]);
        chk("ovf_wrap", ov0, ovexp[0]);
        chk("ovf_sat", ov1, ovexp[1]);
        chk("pd_wrap", pd0, pdexp[0]);
        chk("pd_sat", pd1, pdexp[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(input bit v, input logic [7:0] op, input longint av,
                          input longint bv, input longint dv, input longint cv);
        ce = 1'b1; rstp = 1'b0; in_valid = v; opmode = op;
        a = 18'(av); b = 18'(bv); d = 18'(dv); c = 48'(cv); pcin = '0;
    endtask

    task automatic bubble();
        set_in(1'b0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic rand_in();
        ce = ($urandom_range(0, 9) < 8);
        rstp = ($urandom_range(0, 49) == 0);
        in_valid = ($urandom_range(0, 9) < 7);
        opmode = 8'($urandom);
        a = 18'($urandom); b = 18'($urandom); d = 18'($urandom);
        c = 48'({$urandom, $urandom});
        pcin = 48'({$urandom, $urandom});
        if ($urandom_range(0, 3) == 0) c = 48'h7FFF_FFFF_FF00;
    endtask

    bit ce_seq[10] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    bit v_seq[10]  = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    logic [47:0] got[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bubble();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_p", p0, 48'd0);
        chk("rst_m", m0, 37'd0);
        chk("rst_vo", vo0, 1'b0);
        chk("rst_pd", pd0, 1'b0);
        rst_n = 1'b1;
        reset_model();

        // Plain multiply, 4-cycle latency
        set_in(1'b1, 8'h01, 3, 5, 0, 0);
        step();
        bubble();
        step();
        step();
        chk("mul_vo_early", vo0, 1'b0);
        step();
        chk("mul_p", p0, 48'd15);
        chk("mul_vo", vo0, 1'b1);

        // Pre-subtract, then post-add vs post-subtract
        set_in(1'b1, 8'h5D, -2, 3, 7, 100);
        step();
        set_in(1'b1, 8'hDD, -2, 3, 7, 100);
        step();
        bubble();
        step();
        step();
        chk("pre_add_p", p0, 48'd92);
        step();
        chk("pre_sub_p", p0, 48'd108);
        step();

        // Accumulate with a bubble and a 2-cycle stall
        bubble();
        rstp = 1'b1;
        step();
        chk("rstp_clear", p0, 48'd0);
        for (int i = 0; i < 10; i++) begin
            set_in(v_seq[i], 8'h09, 1, 2, 0, 0);
            ce = ce_seq[i];
            step();
            if (ce_seq[i] && vo0) got.push_back(p0);
        end
        chk("acc_pulses", 64'(got.size()), 64'd3);
        chk("acc_p0", got[0], 48'd2);
        chk("acc_p1", got[1], 48'd4);
        chk("acc_p2", got[2], 48'd6);

        // Overflow: wrap vs clamp
        set_in(1'b1, 8'h0D, 1, 1, 0, MAXP);
        step();
        bubble();
        repeat (3) step();
        chk("wrap_p", p0, 48'h8000_0000_0000);
        chk("wrap_ovf", ov0, 1'b1);
        chk("sat_p", p1, 48'h7FFF_FFFF_FFFF);
        chk("sat_ovf", ov1, 1'b1);

        // Pattern detect, then RSTP against a valid stage-3 sample
        set_in(1'b1, 8'h0C, 0, 0, 0, 64'h1240);
        step();
        bubble();
        repeat (3) step();
        chk("pd_p", p0, 48'h1240);
        chk("pd_hit", pd0, 1'b1);
        set_in(1'b1, 8'h0C, 0, 0, 0, 64'h1240);
        step();
        bubble();
        repeat (2) step();
        rstp = 1'b1;
        step();
        chk("rstp_p", p0, 48'd0);
        chk("rstp_pd", pd0, 1'b0);
        chk("rstp_vo", vo0, 1'b1);

        // Random mix of modes, stalls, bubbles and clears
        for (int i = 0; i < 200; i++) begin
            rand_in();
            step();
        end

        // Asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_p", p0, 48'd0);
        chk("arst_m", m0, 37'd0);
        chk("arst_vo", vo0, 1'b0);
        chk("arst_p_sat", p1, 48'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        set_in(1'b1, 8'h01, 3, 5, 0, 0);
        step();
        bubble();
        step();
        step();
        chk("post_rst_vo_early", vo0, 1'b0);
        step();
        chk("post_rst_vo", vo0, 1'b1);
        chk("post_rst_p", p0, 48'd15);

        for (int i = 0; i < 100; i++) begin
            rand_in();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
